// File: rtl/hdmi_sample_row_mapper_if.sv
// Sample-in / row-out handshake bundle between the ADC feeder and the HDMI controller.
// master drives samples, height and row_ready; slave is the mapper itself.
interface hdmi_sample_row_mapper_if #(
    parameter int unsigned VAL_RES = 16,
    parameter int unsigned DROP_W  = 16
);
    logic [VAL_RES-1:0] sample_in;
    logic               sample_valid;
    logic               sample_ready;
    logic [31:0]        height;
    logic [31:0]        row_out;
    logic               row_valid;
    logic               row_ready;
    logic [DROP_W-1:0]  drop_cnt;

    modport master (
        output sample_in, sample_valid, height, row_ready,
        input  sample_ready, row_out, row_valid, drop_cnt
    );

    modport slave (
        input  sample_in, sample_valid, height, row_ready,
        output sample_ready, row_out, row_valid, drop_cnt
    );
endinterface

// File: rtl/hdmi_sample_row_mapper.sv
// Averages groups of 2^AVG_LOG2 ADC samples and maps each average to a screen row,
// full scale at row 0, presented on a valid/ready handshake to the HDMI controller.
module hdmi_sample_row_mapper #(
    parameter int unsigned VAL_RES  = 16,
    parameter int unsigned AVG_LOG2 = 2,
    parameter int unsigned DROP_W   = 16
) (
    input logic                        writeclk,
    input logic                        rst,
    hdmi_sample_row_mapper_if.slave    bus
);
    localparam int unsigned SUM_W   = VAL_RES + AVG_LOG2;
    localparam int unsigned CNT_W   = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
    localparam int unsigned PROD_W  = VAL_RES + 32;
    localparam int unsigned CNT_MAX = (1 << AVG_LOG2) - 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CNT_MAX);
    localparam logic [VAL_RES-1:0] VAL_MAX  = '1;
    localparam logic [DROP_W-1:0]  DROP_MAX = '1;

    typedef enum logic [1:0] {StAccum, StDiff, StMul, StHold} state_e;

    state_e              state_q, state_d;
    logic [SUM_W-1:0]    sum_q, sum_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [VAL_RES-1:0]  avg_q, avg_d;
    logic [VAL_RES-1:0]  diff_q, diff_d;
    logic [31:0]         hgt_q, hgt_d;
    logic [31:0]         row_q, row_d;
    logic                row_valid_q, row_valid_d;
    logic [DROP_W-1:0]   drop_q, drop_d;

    logic                sample_ready;
    logic                accept;
    logic [SUM_W-1:0]    sum_next;
    logic [PROD_W-1:0]   prod;

    assign sample_ready = (state_q == StAccum);
    assign accept       = bus.sample_valid & sample_ready;
    assign sum_next     = sum_q + SUM_W'(bus.sample_in);
    assign prod         = PROD_W'(diff_q) * PROD_W'(hgt_q);

    assign bus.sample_ready = sample_ready;
    assign bus.row_out      = row_q;
    assign bus.row_valid    = row_valid_q;
    assign bus.drop_cnt     = drop_q;

    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        avg_d       = avg_q;
        diff_d      = diff_q;
        hgt_d       = hgt_q;
        row_d       = row_q;
        row_valid_d = row_valid_q;
        drop_d      = drop_q;

        if (bus.sample_valid && !sample_ready && drop_q != DROP_MAX) begin
            drop_d = drop_q + DROP_W'(1);
        end

        unique case (state_q)
            StAccum: begin
                if (accept) begin
                    if (AVG_LOG2 == 0 || cnt_q == CNT_LAST) begin
                        avg_d   = VAL_RES'(sum_next >> AVG_LOG2);
                        hgt_d   = (bus.height == 32'd0) ? 32'd0 : bus.height - 32'd1;
                        sum_d   = '0;
                        cnt_d   = '0;
                        state_d = StDiff;
                    end else begin
                        sum_d = sum_next;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            StDiff: begin
                diff_d  = VAL_MAX - avg_q;
                state_d = StMul;
            end
            StMul: begin
                // diff <= VAL_MAX keeps the shifted product within 0..hgt
                row_d       = prod[PROD_W-1:VAL_RES];
                row_valid_d = 1'b1;
                state_d     = StHold;
            end
            StHold: begin
                if (bus.row_ready) begin
                    row_valid_d = 1'b0;
                    state_d     = StAccum;
                end
            end
            default: state_d = StAccum;
        endcase
    end

    always_ff @(posedge writeclk) begin
        if (rst) begin
            state_q     <= StAccum;
            sum_q       <= '0;
            cnt_q       <= '0;
            avg_q       <= '0;
            diff_q      <= '0;
            hgt_q       <= '0;
            row_q       <= '0;
            row_valid_q <= 1'b0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            avg_q       <= avg_d;
            diff_q      <= diff_d;
            hgt_q       <= hgt_d;
            row_q       <= row_d;
            row_valid_q <= row_valid_d;
            drop_q      <= drop_d;
        end
    end
endmodule

// File: tb/tb_hdmi_sample_row_mapper.sv
// Directed bench for hdmi_sample_row_mapper: default instance plus a DROP_W=4 instance
// for counter saturation.
module tb_hdmi_sample_row_mapper;
    logic writeclk = 1'b0;
    logic rst      = 1'b1;
    int   n_cmp    = 0;
    int   n_fail   = 0;
    int   lat;
    logic [31:0] held_row;

    always #5 writeclk = ~writeclk;

    hdmi_sample_row_mapper_if #(.VAL_RES(16), .DROP_W(16)) bus ();
    hdmi_sample_row_mapper_if #(.VAL_RES(16), .DROP_W(4))  bus4 ();

    hdmi_sample_row_mapper #(.VAL_RES(16), .AVG_LOG2(2), .DROP_W(16)) dut (
        .writeclk (writeclk),
        .rst      (rst),
        .bus      (bus.slave)
    );

    hdmi_sample_row_mapper #(.VAL_RES(16), .AVG_LOG2(2), .DROP_W(4)) dut4 (
        .writeclk (writeclk),
        .rst      (rst),
        .bus      (bus4.slave)
    );

    task automatic tick();
        @(posedge writeclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send_group(input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] c, input logic [15:0] d);
        logic [15:0] s [4];
        s[0] = a; s[1] = b; s[2] = c; s[3] = d;
        for (int i = 0; i < 4; i++) begin
            bus.sample_in    = s[i];
            bus.sample_valid = 1'b1;
            tick();
        end
        bus.sample_valid = 1'b0;
    endtask

    // Observes cycle T+1 first; lat is the cycle offset at which row_valid is seen.
    task automatic wait_row(output int l);
        l = 1;
        while (!bus.row_valid && l < 20) begin
            tick();
            l++;
        end
    endtask

    task automatic consume();
        bus.row_ready = 1'b1;
        tick();
        bus.row_ready = 1'b0;
    endtask

    initial begin
        bus.sample_in     = '0;
        bus.sample_valid  = 1'b0;
        bus.height        = 32'd480;
        bus.row_ready     = 1'b0;
        bus4.sample_in    = '0;
        bus4.sample_valid = 1'b0;
        bus4.height       = 32'd480;
        bus4.row_ready    = 1'b0;

        tick();
        tick();
        rst = 1'b0;
        check("reset_row_valid", 32'(bus.row_valid), 32'd0);
        check("reset_row_out", bus.row_out, 32'd0);
        check("reset_drop_cnt", 32'(bus.drop_cnt), 32'd0);
        tick();
        check("reset_sample_ready", 32'(bus.sample_ready), 32'd1);

        // T1: avg 0xF000 -> diff 4095, 4095*479 >> 16 = 29
        send_group(16'hF000, 16'hF000, 16'hF000, 16'hF000);
        check("t1_ready_low_diff", 32'(bus.sample_ready), 32'd0);
        wait_row(lat);
        check("t1_latency", 32'(lat), 32'd3);
        check("t1_row_valid", 32'(bus.row_valid), 32'd1);
        check("t1_row_out", bus.row_out, 32'd29);
        consume();
        check("t1_row_valid_clear", 32'(bus.row_valid), 32'd0);

        // T2: 65535*479>>16 = 478; full scale -> 0; avg 0x7FFF -> 32768*479>>16 = 239
        send_group(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        wait_row(lat);
        check("t2_zero_row", bus.row_out, 32'd478);
        consume();
        send_group(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        wait_row(lat);
        check("t2_full_row", bus.row_out, 32'd0);
        consume();
        send_group(16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF);
        wait_row(lat);
        check("t2_mid_row", bus.row_out, 32'd239);
        consume();

        // T3: backpressure with sample_valid held high
        send_group(16'hF000, 16'hF000, 16'hF000, 16'hF000);
        wait_row(lat);
        check("t3_row_valid", 32'(bus.row_valid), 32'd1);
        bus.sample_in    = 16'h0000;
        bus.sample_valid = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("t3_sample_ready_low", 32'(bus.sample_ready), 32'd0);
        check("t3_row_still_valid", 32'(bus.row_valid), 32'd1);
        check("t3_row_stable", bus.row_out, 32'd29);
        check("t3_drop_cnt", 32'(bus.drop_cnt), 32'd10);
        bus.row_ready = 1'b1;
        tick();
        bus.row_ready = 1'b0;
        check("t3_row_valid_drop", 32'(bus.row_valid), 32'd0);
        check("t3_sample_ready_back", 32'(bus.sample_ready), 32'd1);
        check("t3_drop_after_pulse", 32'(bus.drop_cnt), 32'd11);
        // This cycle's zero sample must be accepted: three more complete the group.
        tick();
        check("t3_no_drop_accept", 32'(bus.drop_cnt), 32'd11);
        tick();
        tick();
        tick();
        bus.sample_valid = 1'b0;
        wait_row(lat);
        check("t3_next_group_row", bus.row_out, 32'd478);
        consume();

        // T4: height 0 -> hgt 0 -> row 0
        bus.height = 32'd0;
        send_group(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        wait_row(lat);
        check("t4_height0_row", bus.row_out, 32'd0);
        consume();
        bus.height = 32'd480;
        send_group(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        wait_row(lat);
        held_row   = bus.row_out;
        bus.height = 32'd240;
        tick();
        tick();
        check("t4_hold_height_change", bus.row_out, 32'd478);
        consume();
        // height 240 -> hgt 239; 65535*239 >> 16 = 238
        send_group(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        wait_row(lat);
        check("t4_new_height_row", bus.row_out, 32'd238);
        consume();
        bus.height = 32'd480;

        // T5: rst mid-group, then rst in MUL
        bus.sample_in    = 16'hFFFF;
        bus.sample_valid = 1'b1;
        tick();
        tick();
        bus.sample_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_rst1_sample_ready", 32'(bus.sample_ready), 32'd1);
        check("t5_rst1_drop_cnt", 32'(bus.drop_cnt), 32'd0);
        send_group(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_rst2_row_valid", 32'(bus.row_valid), 32'd0);
        check("t5_rst2_row_out", bus.row_out, 32'd0);
        check("t5_rst2_sample_ready", 32'(bus.sample_ready), 32'd1);
        tick();
        tick();
        tick();
        check("t5_no_late_row", 32'(bus.row_valid), 32'd0);
        send_group(16'hF000, 16'hF000, 16'hF000, 16'hF000);
        wait_row(lat);
        check("t5_fresh_latency", 32'(lat), 32'd3);
        check("t5_fresh_row", bus.row_out, 32'd29);
        consume();

        // T6: DROP_W=4 instance; 4 accepts then drops with row never consumed
        bus4.sample_valid = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        check("t6_drop_10", 32'(bus4.drop_cnt), 32'd10);
        for (int i = 0; i < 16; i++) tick();
        check("t6_drop_sat", 32'(bus4.drop_cnt), 32'd15);
        check("t6_row_held", 32'(bus4.row_valid), 32'd1);
        bus4.sample_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
